// File: rtl/seq_pkg.sv
// Shared types and constants for the SEQ Y86-64 stage sequencer.
package seq_pkg;

  // Controller states, one per processing stage plus idle and stopped.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PCUPDATE  = 3'd6,
    ST_STOPPED   = 3'd7
  } state_e;

  // Architectural status codes.
  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  // Y86-64 instruction codes.
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/seq_icode_class.sv
// Classifies an instruction code: does it touch data memory, does it write a register.
module seq_icode_class
  import seq_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       needs_mem_o,
  output logic       writes_reg_o
);

  // Table lookup of the two instruction properties.
  always_comb begin
    needs_mem_o  = 1'b0;
    writes_reg_o = 1'b0;
    case (icode_i)
      I_RRMOVQ, I_IRMOVQ, I_OPQ: writes_reg_o = 1'b1;
      I_RMMOVQ:                  needs_mem_o  = 1'b1;
      I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: begin
        needs_mem_o  = 1'b1;
        writes_reg_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer: steps each instruction through F/D/E/M/W/P,
// handshakes with data memory, tracks status and stops on halt or error.
module seq_stage_controller
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         icode,
  input  logic               imem_error,
  input  logic               instr_invalid,
  input  logic               dmem_ack,
  input  logic               dmem_error,
  input  logic               regerr,
  output logic               fetch_en,
  output logic               reEn,
  output logic               exec_en,
  output logic               dmem_req,
  output logic               wrEn,
  output logic               pc_en,
  output logic [1:0]         stat,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  // Wide enough to hold MEM_TIMEOUT-1, the index of the last permitted wait cycle.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  stat_e              stat_q, stat_d;
  logic [3:0]         icode_q, icode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               needs_mem;
  logic               writes_reg;

  seq_icode_class u_icode_class (
    .icode_i      (icode_q),
    .needs_mem_o  (needs_mem),
    .writes_reg_o (writes_reg)
  );

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= I_HALT;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; errors are checked in priority order within each stage.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    wait_d  = wait_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        icode_d = icode;
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = ST_STOPPED;
        end else if (instr_invalid) begin
          stat_d  = STAT_INS;
          state_d = ST_STOPPED;
        end else if (icode == I_HALT) begin
          stat_d  = STAT_HLT;
          count_d = count_q + COUNT_W'(1);
          state_d = ST_STOPPED;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        wait_d  = '0;
        state_d = needs_mem ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (dmem_ack) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = ST_STOPPED;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = ST_STOPPED;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WRITEBACK: begin
        if (regerr) begin
          stat_d  = STAT_INS;
          state_d = ST_STOPPED;
        end else begin
          state_d = ST_PCUPDATE;
        end
      end
      ST_PCUPDATE: begin
        count_d = count_q + COUNT_W'(1);
        state_d = ST_FETCH;
      end
      ST_STOPPED: state_d = ST_STOPPED;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    fetch_en    = (state_q == ST_FETCH);
    reEn        = (state_q == ST_DECODE);
    exec_en     = (state_q == ST_EXECUTE);
    dmem_req    = (state_q == ST_MEMORY);
    wrEn        = (state_q == ST_WRITEBACK) && writes_reg;
    pc_en       = (state_q == ST_PCUPDATE);
    halted      = (state_q == ST_STOPPED);
    stat        = stat_q;
    instr_count = count_q;
  end

endmodule
